sd_cmd_wb_master: RTL and testbench

//  Wishbone master that issues one SD command through the SD controller register slave. Sequence per request:
//   - write command setting (0x04), then argument (0x00); the argument write starts the command;
//   - poll normal ISR (0x30) until complete or error, then read error ISR (0x34) if flagged;
//   - read RESP1 (0x0c), clear the ISRs and return response plus status to the local requester.

---
 rtl/sd_cmd_wb_master.sv | 184 ++++++++++++++++++
 tb/tb_sd_cmd_wb_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_wb_master.sv
// Wishbone master that runs one SD command through the controller register slave:
// write setting and argument, poll the normal ISR, read error ISR / RESP1, clear ISRs, report.
module sd_cmd_wb_master #(
  parameter int POLL_GAP    = 16,
  parameter int MAX_POLLS   = 4096,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_cmd,
  input  logic [31:0] req_arg,
  output logic        done,
  output logic [31:0] resp,
  output logic [15:0] err_isr,
  output logic [1:0]  status,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);
  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(POLL_GAP + 1);

  localparam logic [7:0] ADR_ARG  = 8'h00;
  localparam logic [7:0] ADR_CMD  = 8'h04;
  localparam logic [7:0] ADR_RESP = 8'h0c;
  localparam logic [7:0] ADR_NISR = 8'h30;
  localparam logic [7:0] ADR_EISR = 8'h34;

  typedef enum logic [3:0] {
    IDLE, WR_CMD, WR_ARG, GAP, RD_NISR, RD_EISR, RD_RESP, CLR_NISR, CLR_EISR, DONE
  } state_t;

  state_t        state;
  logic [15:0]   cmd_q;
  logic [31:0]   arg_q;
  logic [PW-1:0] poll_cnt;
  logic [AW-1:0] ack_cnt;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    acc_adr;
  logic          acc_we;
  logic [31:0]   acc_dat;

  assign wb_sel_o = 4'hF;

  // Address, direction and write data of the access owned by the current state.
  always_comb begin
    acc_adr = 8'h00;
    acc_we  = 1'b0;
    acc_dat = 32'h0000_0000;
    case (state)
      WR_CMD:   begin acc_adr = ADR_CMD;  acc_we = 1'b1; acc_dat = {16'h0000, cmd_q}; end
      WR_ARG:   begin acc_adr = ADR_ARG;  acc_we = 1'b1; acc_dat = arg_q; end
      RD_NISR:  acc_adr = ADR_NISR;
      RD_EISR:  acc_adr = ADR_EISR;
      RD_RESP:  acc_adr = ADR_RESP;
      CLR_NISR: begin acc_adr = ADR_NISR; acc_we = 1'b1; end
      CLR_EISR: begin acc_adr = ADR_EISR; acc_we = 1'b1; end
      default:  acc_adr = 8'h00;
    endcase
  end

  // Sequencer: request handshake, bus accesses, poll pacing and result latching.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cmd_q     <= 16'h0000;
      arg_q     <= 32'h0000_0000;
      poll_cnt  <= '0;
      ack_cnt   <= '0;
      gap_cnt   <= '0;
      req_ready <= 1'b1;
      done      <= 1'b0;
      resp      <= 32'h0000_0000;
      err_isr   <= 16'h0000;
      status    <= 2'd0;
      wb_adr_o  <= 8'h00;
      wb_dat_o  <= 32'h0000_0000;
      wb_we_o   <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cmd_q     <= req_cmd;
            arg_q     <= req_arg;
            status    <= 2'd0;
            err_isr   <= 16'h0000;
            req_ready <= 1'b0;
            state     <= WR_CMD;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(POLL_GAP - 1)) begin
            gap_cnt <= '0;
            state   <= RD_NISR;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        WR_CMD, WR_ARG, RD_NISR, RD_EISR, RD_RESP, CLR_NISR, CLR_EISR: begin
          // Bus idle on entry, so every access is preceded by at least one low cycle.
          if (!wb_cyc_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_adr_o <= acc_adr;
            wb_we_o  <= acc_we;
            wb_dat_o <= acc_dat;
            ack_cnt  <= '0;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            case (state)
              WR_CMD: state <= WR_ARG;
              WR_ARG: begin
                poll_cnt <= '0;
                gap_cnt  <= '0;
                state    <= GAP;
              end
              RD_NISR: begin
                if (wb_dat_i[15]) begin
                  state <= RD_EISR;
                end else if (wb_dat_i[0]) begin
                  state <= RD_RESP;
                end else if (poll_cnt == PW'(MAX_POLLS - 1)) begin
                  poll_cnt <= poll_cnt + 1'b1;
                  status   <= 2'd2;
                  state    <= CLR_NISR;
                end else begin
                  poll_cnt <= poll_cnt + 1'b1;
                  gap_cnt  <= '0;
                  state    <= GAP;
                end
              end
              RD_EISR: begin
                err_isr <= wb_dat_i[15:0];
                status  <= 2'd1;
                state   <= RD_RESP;
              end
              RD_RESP: begin
                resp  <= wb_dat_i;
                state <= CLR_NISR;
              end
              CLR_NISR: state <= CLR_EISR;
              CLR_EISR: begin
                done  <= 1'b1;
                state <= DONE;
              end
              default: state <= IDLE;
            endcase
          end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            status   <= 2'd3;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_wb_master.sv
// Bench for sd_cmd_wb_master: reactive register-slave model, access-list reference model,
// directed vector table, ack-latency sweep, mid-poll reset and randomized requests.
module tb_sd_cmd_wb_master;
  localparam int POLL_GAP    = 3;
  localparam int MAX_POLLS   = 8;
  localparam int ACK_TIMEOUT = 10;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_cmd;
  logic [31:0] req_arg;
  logic        done;
  logic [31:0] resp;
  logic [15:0] err_isr;
  logic [1:0]  status;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  sd_cmd_wb_master #(.POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_arg(req_arg), .done(done), .resp(resp), .err_isr(err_isr),
    .status(status), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [7:0]  adr;
    logic        we;
    logic [31:0] dat;
  } acc_t;

  typedef struct {
    logic [15:0] cmd;
    logic [31:0] arg;
    int          ok_poll;   // poll number that reports complete/error, 0 = never
    bit          err;
    logic [15:0] eisr;
    logic [31:0] resp1;
    bit          hang;      // slave never acks the argument write
    logic [1:0]  exp_status;
    logic [15:0] exp_err;
    logic [31:0] exp_resp;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  vec_t cfg;
  int   wmin = 0, wmax = 0;
  acc_t log_q[$];
  acc_t exp_q[$];
  int   n_starts, max_run, poll_idx;
  bit   poll_seen;
  logic [1:0]  m_status;
  logic [15:0] m_err;
  logic [31:0] m_resp = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected access list and results, straight from the command sequence rules.
  task automatic build_model(input vec_t s);
    int polls;
    bit hit;
    exp_q.delete();
    m_err = 16'h0;
    exp_q.push_back('{adr: 8'h04, we: 1'b1, dat: {16'h0, s.cmd}});
    if (s.hang) begin
      m_status = 2'd3;
    end else begin
      exp_q.push_back('{adr: 8'h00, we: 1'b1, dat: s.arg});
      hit   = (s.ok_poll >= 1) && (s.ok_poll <= MAX_POLLS);
      polls = hit ? s.ok_poll : MAX_POLLS;
      for (int i = 0; i < polls; i++) exp_q.push_back('{adr: 8'h30, we: 1'b0, dat: 32'h0});
      if (hit) begin
        m_status = 2'd0;
        if (s.err) begin
          exp_q.push_back('{adr: 8'h34, we: 1'b0, dat: 32'h0});
          m_status = 2'd1;
          m_err    = s.eisr;
        end
        exp_q.push_back('{adr: 8'h0c, we: 1'b0, dat: 32'h0});
        m_resp = s.resp1;
      end else begin
        m_status = 2'd2;
      end
      exp_q.push_back('{adr: 8'h30, we: 1'b1, dat: 32'h0});
      exp_q.push_back('{adr: 8'h34, we: 1'b1, dat: 32'h0});
    end
  endtask

  // Register slave plus bus protocol monitor, acting on falling edges.
  initial begin
    bit p_stb, p_ack;
    logic [7:0] p_adr;
    logic p_we;
    logic [31:0] p_dat;
    int run, wt, idle;
    logic [31:0] d;
    p_stb = 1'b0; p_ack = 1'b0; run = 0; wt = 0; idle = 0;
    p_adr = 8'h0; p_we = 1'b0; p_dat = 32'h0;
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i) begin
        wb_ack_i = 1'b0; p_stb = 1'b0; p_ack = 1'b0; run = 0; idle = 0;
        continue;
      end
      if (wb_stb_o) begin
        if (!wb_cyc_o) begin errors++; $display("FAIL stb_without_cyc: cyc %b stb %b", wb_cyc_o, wb_stb_o); end
        if (p_stb && !p_ack) begin
          if (wb_adr_o !== p_adr || wb_we_o !== p_we || wb_dat_o !== p_dat) begin
            errors++;
            $display("FAIL bus_stable: adr %h we %b dat %h, was %h %b %h", wb_adr_o, wb_we_o, wb_dat_o, p_adr, p_we, p_dat);
          end
          run++;
        end else begin
          checks++;
          if (p_stb && p_ack) begin errors++; $display("FAIL idle_gap: 0 idle cycles, need >= 1"); end
          if (wb_adr_o == 8'h30 && !wb_we_o) begin
            if (poll_seen) begin
              checks++;
              if (idle < POLL_GAP) begin errors++; $display("FAIL poll_gap: idle %0d cycles, need >= %0d", idle, POLL_GAP); end
            end
            poll_seen = 1'b1;
          end
          n_starts++;
          run = 1;
          wt = $urandom_range(wmax, wmin);
          p_adr = wb_adr_o; p_we = wb_we_o; p_dat = wb_dat_o;
        end
        if (run > max_run) max_run = run;
        idle = 0;
      end else begin
        if (p_stb && !p_ack && !cfg.hang) begin errors++; $display("FAIL stb_dropped: no ack seen, got stb 0 expected 1"); end
        idle++;
      end
      wb_ack_i = 1'b0;
      if (wb_stb_o && (run - 1) >= wt && !(cfg.hang && wb_adr_o == 8'h00 && wb_we_o)) begin
        d = 32'h0;
        case (wb_adr_o)
          8'h30: begin
            poll_idx++;
            d = $urandom & 32'hFFFF_7FFE;
            if (!wb_we_o && poll_idx == cfg.ok_poll) d = cfg.err ? (d | 32'h8001) : (d | 32'h0001);
          end
          8'h34:   d = {16'h0, cfg.eisr};
          8'h0c:   d = cfg.resp1;
          default: d = $urandom;
        endcase
        wb_dat_i = d;
        wb_ack_i = 1'b1;
        log_q.push_back('{adr: wb_adr_o, we: wb_we_o, dat: wb_we_o ? wb_dat_o : 32'h0});
      end
      p_stb = wb_stb_o;
      p_ack = wb_ack_i;
    end
  end

  task automatic start_req(input vec_t s);
    int n;
    cfg = s;
    log_q.delete();
    n_starts = 0; max_run = 0; poll_idx = 0; poll_seen = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge wb_clk_i); n++; end
    chk("ready_before_req", req_ready, 1'b1);
    req_cmd = s.cmd; req_arg = s.arg; req_valid = 1'b1;
    @(negedge wb_clk_i);
    req_valid = 1'b0;
    chk("ready_low_busy", req_ready, 1'b0);
    chk("status_cleared", status, 2'd0);
    chk("err_isr_cleared", err_isr, 16'h0);
  endtask

  task automatic finish_req(input logic [1:0] es, input logic [15:0] ee, input logic [31:0] er, input bit pulse);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 4000) begin
      if (pulse && n == 4) begin req_valid = 1'b1; req_cmd = 16'hDEAD; end
      else req_valid = 1'b0;
      @(negedge wb_clk_i);
      n++;
    end
    req_valid = 1'b0;
    chk("done_seen", done, 1'b1);
    chk("status", status, es);
    chk("err_isr", err_isr, ee);
    chk("resp", resp, er);
    chk("access_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("access%0d", i), {log_q[i].adr, 3'b0, log_q[i].we, log_q[i].dat[19:0]},
          {exp_q[i].adr, 3'b0, exp_q[i].we, exp_q[i].dat[19:0]});
    chk("access_starts", n_starts, exp_q.size() + (cfg.hang ? 1 : 0));
    if (cfg.hang) chk("stb_cycles_to_timeout", max_run, ACK_TIMEOUT);
    else begin
      checks++;
      if (max_run > wmax + 1) begin errors++; $display("FAIL stb_run: %0d cycles, allowed %0d", max_run, wmax + 1); end
    end
    @(negedge wb_clk_i);
    chk("done_one_cycle", done, 1'b0);
    chk("ready_after_done", req_ready, 1'b1);
    if (pulse) begin
      repeat (3) @(negedge wb_clk_i);
      chk("busy_req_ignored", {wb_cyc_o, req_ready}, 2'b01);
    end
  endtask

  task automatic run_req(input vec_t s, input logic [1:0] es, input logic [15:0] ee, input logic [31:0] er, input bit pulse);
    start_req(s);
    finish_req(es, ee, er, pulse);
  endtask

  vec_t tbl[6];
  vec_t v;
  int   n;

  initial begin
    cfg = '{16'h0, 32'h0, 0, 1'b0, 16'h0, 32'h0, 1'b0, 2'd0, 16'h0, 32'h0};
    wb_rst_i = 1'b1; req_valid = 1'b0; req_cmd = 16'h0; req_arg = 32'h0;
    //             cmd       arg           poll err eisr     resp1         hang status err      resp
    tbl[0] = '{16'h0119, 32'h0000_1000, 3, 1'b0, 16'h0000, 32'h0000_0900, 1'b0, 2'd0, 16'h0000, 32'h0000_0900};
    tbl[1] = '{16'h0219, 32'h0000_0000, 1, 1'b1, 16'h0002, 32'h1234_5678, 1'b0, 2'd1, 16'h0002, 32'h1234_5678};
    tbl[2] = '{16'h0319, 32'hCAFE_0001, 0, 1'b0, 16'h0000, 32'h0000_AAAA, 1'b0, 2'd2, 16'h0000, 32'h1234_5678};
    tbl[3] = '{16'h0419, 32'hDEAD_BEEF, 2, 1'b0, 16'h0000, 32'h0000_BBBB, 1'b1, 2'd3, 16'h0000, 32'h1234_5678};
    tbl[4] = '{16'h0519, 32'h0000_0055, 8, 1'b0, 16'h0000, 32'h0000_0055, 1'b0, 2'd0, 16'h0000, 32'h0000_0055};
    tbl[5] = '{16'h0619, 32'h0000_0066, 9, 1'b0, 16'h0000, 32'h0000_CCCC, 1'b0, 2'd2, 16'h0000, 32'h0000_0055};

    repeat (2) @(negedge wb_clk_i);
    chk("rst_cyc_stb_we", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    chk("rst_adr", wb_adr_o, 8'h00);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_ready_done", {req_ready, done}, 2'b10);
    chk("rst_results", {resp, err_isr, status}, 50'h0);
    chk("sel", wb_sel_o, 4'hF);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    wmin = 0; wmax = 2;
    for (int i = 0; i < 6; i++) begin
      build_model(tbl[i]);
      run_req(tbl[i], tbl[i].exp_status, tbl[i].exp_err, tbl[i].exp_resp, 1'b0);
    end

    // Ack-latency sweep with a stray request pulsed while busy.
    for (int w = 0; w <= 5; w++) begin
      wmin = w; wmax = w;
      build_model(tbl[0]);
      run_req(tbl[0], 2'd0, 16'h0, 32'h0000_0900, 1'b1);
      chk($sformatf("stb_run_w%0d", w), max_run, w + 1);
    end

    // Reset while a normal-ISR read strobe is outstanding.
    wmin = 2; wmax = 2;
    v = tbl[2];
    start_req(v);
    n = 0;
    while (!(wb_stb_o === 1'b1 && wb_adr_o == 8'h30) && n < 200) begin @(negedge wb_clk_i); n++; end
    chk("reached_poll", {wb_stb_o, wb_adr_o}, {1'b1, 8'h30});
    #2 wb_rst_i = 1'b1;
    #1 chk("async_bus_release", {wb_cyc_o, wb_stb_o}, 2'b00);
    @(negedge wb_clk_i);
    #2 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("ready_after_reset", {req_ready, done}, 2'b10);
    chk("results_after_reset", {resp, status}, 34'h0);
    m_resp = 32'h0;
    build_model(tbl[0]);
    run_req(tbl[0], 2'd0, 16'h0, 32'h0000_0900, 1'b0);

    // Randomized requests against the reference model.
    for (int i = 0; i < 14; i++) begin
      v.cmd = $urandom; v.arg = $urandom;
      v.ok_poll = $urandom_range(10, 0);
      v.err = $urandom_range(1, 0);
      v.eisr = $urandom; v.resp1 = $urandom;
      v.hang = ($urandom_range(7, 0) == 0);
      wmin = 0; wmax = $urandom_range(5, 0);
      build_model(v);
      run_req(v, m_status, m_err, m_resp, i[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
